// File: rtl/stream_strip_to_xy.sv
// Strips dummy column/row samples from an extended pixel stream and tags each
// real pixel with its (x,y) coordinate; optional per-frame warm-up skip.
module stream_strip_to_xy #(
    parameter int unsigned WIDTH       = 430,
    parameter int unsigned HEIGHT      = 554,
    parameter int unsigned SKIP        = 0,
    parameter logic [7:0]  DUMMY       = 8'h00,
    parameter bit          CHECK_DUMMY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_pixel,
    output logic        out_valid,
    output logic [7:0]  out_pixel,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic        out_last,
    output logic        done,
    output logic        dummy_err
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned LINE_W = WIDTH + 1;

    typedef enum logic {S_SKIP, S_PASS} state_t;

    localparam state_t FRAME_START = (SKIP > 0) ? S_SKIP : S_PASS;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  skip_cnt_q, skip_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_pixel_q, out_pixel_d;
    logic [CNT_W-1:0]  out_x_q, out_x_d;
    logic [CNT_W-1:0]  out_y_q, out_y_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              dummy_err_q, dummy_err_d;

    logic [CNT_W-1:0]  skip_nxt;
    logic              is_real;
    logic              end_of_line;

    assign skip_nxt    = skip_cnt_q + CNT_W'(1);
    assign is_real     = (col_q < CNT_W'(WIDTH)) && (row_q < CNT_W'(HEIGHT));
    assign end_of_line = (col_q == CNT_W'(LINE_W - 1));

    // Next-state, counter advance and registered output values.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        skip_cnt_d  = skip_cnt_q;
        out_valid_d = 1'b0;
        out_pixel_d = out_pixel_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_last_d  = 1'b0;
        done_d      = 1'b0;
        dummy_err_d = 1'b0;

        if (in_valid) begin
            if (state_q == S_SKIP) begin
                // The sample that completes the skip is itself discarded.
                if (skip_nxt == CNT_W'(SKIP)) begin
                    state_d    = S_PASS;
                    col_d      = '0;
                    row_d      = '0;
                    skip_cnt_d = '0;
                end else begin
                    skip_cnt_d = skip_nxt;
                end
            end else begin
                if (is_real) begin
                    out_valid_d = 1'b1;
                    out_pixel_d = in_pixel;
                    out_x_d     = col_q;
                    out_y_d     = row_q;
                    out_last_d  = (col_q == CNT_W'(WIDTH - 1)) &&
                                  (row_q == CNT_W'(HEIGHT - 1));
                end else begin
                    dummy_err_d = CHECK_DUMMY && (in_pixel != DUMMY);
                end

                if (end_of_line) begin
                    col_d = '0;
                    if (row_q == CNT_W'(HEIGHT)) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = FRAME_START;
                    end else begin
                        row_d = row_q + CNT_W'(1);
                    end
                end else begin
                    col_d = col_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FRAME_START;
            col_q       <= '0;
            row_q       <= '0;
            skip_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= DUMMY;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            dummy_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            skip_cnt_q  <= skip_cnt_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            dummy_err_q <= dummy_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign dummy_err = dummy_err_q;

endmodule

// File: tb/tb_stream_strip_to_xy.sv
// Bench for stream_strip_to_xy: three 4x3 instances (plain, SKIP=6, dummy check)
// fed the same stream and checked every cycle against a frame-position model.
module tb_stream_strip_to_xy;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned LW = W + 1;
    localparam int unsigned NI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_pixel = 8'h00;

    logic [NI-1:0] ov, ol, od, oe;
    logic [7:0]    opix [NI];
    logic [31:0]   ox [NI];
    logic [31:0]   oy [NI];

    always #5 clk = ~clk;

    stream_strip_to_xy #(.WIDTH(W), .HEIGHT(H), .SKIP(0), .DUMMY(8'h00), .CHECK_DUMMY(1'b0)) dut_plain (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel),
        .out_valid(ov[0]), .out_pixel(opix[0]), .out_x(ox[0]), .out_y(oy[0]),
        .out_last(ol[0]), .done(od[0]), .dummy_err(oe[0]));

    stream_strip_to_xy #(.WIDTH(W), .HEIGHT(H), .SKIP(6), .DUMMY(8'h00), .CHECK_DUMMY(1'b0)) dut_skip (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel),
        .out_valid(ov[1]), .out_pixel(opix[1]), .out_x(ox[1]), .out_y(oy[1]),
        .out_last(ol[1]), .done(od[1]), .dummy_err(oe[1]));

    stream_strip_to_xy #(.WIDTH(W), .HEIGHT(H), .SKIP(0), .DUMMY(8'h00), .CHECK_DUMMY(1'b1)) dut_chk (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel),
        .out_valid(ov[2]), .out_pixel(opix[2]), .out_x(ox[2]), .out_y(oy[2]),
        .out_last(ol[2]), .done(od[2]), .dummy_err(oe[2]));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int unsigned m_n [NI];
    logic [7:0]  m_pix [NI];
    logic [31:0] m_x [NI];
    logic [31:0] m_y [NI];
    int          cnt_v [NI];
    int          cnt_d [NI];
    int          cnt_e [NI];

    typedef struct {
        logic [7:0]  pix;
        logic        ev;
        logic [7:0]  epix;
        logic [31:0] ex;
        logic [31:0] ey;
        logic        el;
        logic        ed;
    } vec_t;

    vec_t tbl [20];

    function automatic int unsigned skip_of(int k);
        return (k == 1) ? 6 : 0;
    endfunction

    function automatic logic [75:0] dut_out(int k);
        return {ov[k], opix[k], ox[k], oy[k], ol[k], od[k], oe[k]};
    endfunction

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a frame is SKIP discarded samples followed by LW*(H+1) extended samples.
    task automatic model_step(input int k, input logic v, input logic [7:0] p, output logic [75:0] exp);
        int unsigned fr, pos, q, col, row;
        logic ev, el, ed, ee;
        ev = 1'b0; el = 1'b0; ed = 1'b0; ee = 1'b0;
        if (v) begin
            fr  = skip_of(k) + LW * (H + 1);
            pos = m_n[k] % fr;
            m_n[k]++;
            if (pos >= skip_of(k)) begin
                q   = pos - skip_of(k);
                col = q % LW;
                row = q / LW;
                if (col < W && row < H) begin
                    ev = 1'b1;
                    m_pix[k] = p;
                    m_x[k] = col;
                    m_y[k] = row;
                    el = (col == W - 1) && (row == H - 1);
                end else begin
                    ee = (k == 2) && (p != 8'h00);
                end
                ed = (q == LW * (H + 1) - 1);
            end
        end
        exp = {ev, m_pix[k], m_x[k], m_y[k], el, ed, ee};
    endtask

    task automatic step(input logic v, input logic [7:0] p);
        logic [75:0] exp;
        in_valid = v;
        in_pixel = p;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            model_step(k, v, p, exp);
            check($sformatf("out[%0d]", k), dut_out(k), exp);
            if (ov[k]) cnt_v[k]++;
            if (od[k]) cnt_d[k]++;
            if (oe[k]) cnt_e[k]++;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) check($sformatf("rst_async[%0d]", k), dut_out(k), 76'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) check($sformatf("rst_hold[%0d]", k), dut_out(k), 76'd0);
        for (int k = 0; k < NI; k++) begin
            m_n[k] = 0; m_pix[k] = 8'h00; m_x[k] = 0; m_y[k] = 0;
            cnt_v[k] = 0; cnt_d[k] = 0; cnt_e[k] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{8'd0,  1'b1, 8'd0,  32'd0, 32'd0, 1'b0, 1'b0};
        tbl[1]  = '{8'd1,  1'b1, 8'd1,  32'd1, 32'd0, 1'b0, 1'b0};
        tbl[2]  = '{8'd2,  1'b1, 8'd2,  32'd2, 32'd0, 1'b0, 1'b0};
        tbl[3]  = '{8'd3,  1'b1, 8'd3,  32'd3, 32'd0, 1'b0, 1'b0};
        tbl[4]  = '{8'd4,  1'b0, 8'd3,  32'd3, 32'd0, 1'b0, 1'b0};
        tbl[5]  = '{8'd5,  1'b1, 8'd5,  32'd0, 32'd1, 1'b0, 1'b0};
        tbl[6]  = '{8'd6,  1'b1, 8'd6,  32'd1, 32'd1, 1'b0, 1'b0};
        tbl[7]  = '{8'd7,  1'b1, 8'd7,  32'd2, 32'd1, 1'b0, 1'b0};
        tbl[8]  = '{8'd8,  1'b1, 8'd8,  32'd3, 32'd1, 1'b0, 1'b0};
        tbl[9]  = '{8'd9,  1'b0, 8'd8,  32'd3, 32'd1, 1'b0, 1'b0};
        tbl[10] = '{8'd10, 1'b1, 8'd10, 32'd0, 32'd2, 1'b0, 1'b0};
        tbl[11] = '{8'd11, 1'b1, 8'd11, 32'd1, 32'd2, 1'b0, 1'b0};
        tbl[12] = '{8'd12, 1'b1, 8'd12, 32'd2, 32'd2, 1'b0, 1'b0};
        tbl[13] = '{8'd13, 1'b1, 8'd13, 32'd3, 32'd2, 1'b1, 1'b0};
        for (int i = 14; i < 20; i++)
            tbl[i] = '{8'(i), 1'b0, 8'd13, 32'd3, 32'd2, 1'b0, (i == 19)};

        // Plain frame against the hand-written table.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, tbl[i].pix);
            check($sformatf("tbl[%0d]", i), dut_out(0),
                  {tbl[i].ev, tbl[i].epix, tbl[i].ex, tbl[i].ey, tbl[i].el, tbl[i].ed, 1'b0});
        end
        step(1'b0, 8'hAA);
        check_int("tbl_valid_cnt", cnt_v[0], 12);
        check_int("tbl_done_cnt", cnt_d[0], 1);

        // Warm-up skip of 6 samples.
        do_reset();
        for (int i = 0; i < 26; i++) step(1'b1, 8'(i));
        check("skip_last_pixel", {8'(opix[1]), ox[1], oy[1]}, {8'd19, 32'd3, 32'd2});
        check_int("skip_valid_cnt", cnt_v[1], 12);
        check_int("skip_done_cnt", cnt_d[1], 1);

        // Gaps in in_valid.
        do_reset();
        for (int sent = 0; sent < 20;) begin
            if ($urandom_range(0, 99) < 40) begin
                step(1'b1, 8'(sent));
                sent++;
            end else begin
                step(1'b0, 8'($urandom));
            end
        end
        check_int("gap_valid_cnt", cnt_v[0], 12);
        check_int("gap_done_cnt", cnt_d[0], 1);

        // Back-to-back frames.
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 8'(i));
        check_int("b2b_valid_cnt", cnt_v[0], 24);
        check_int("b2b_done_cnt", cnt_d[0], 2);

        // Dummy check: one bad dummy at index 9.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if ((i % LW) == W || i >= LW * H) step(1'b1, (i == 9) ? 8'h55 : 8'h00);
            else step(1'b1, 8'(i + 100));
            if (i == 9) check("dummy_err_pulse", {31'd0, oe[2]}, 32'd1);
        end
        check_int("dummy_err_cnt", cnt_e[2], 1);
        check_int("dummy_valid_cnt", cnt_v[2], 12);

        // Reset mid-frame.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 8'(i + 50));
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i));
        check_int("midrst_valid_cnt", cnt_v[0], 12);
        check_int("midrst_done_cnt", cnt_d[0], 1);
        check("midrst_last_pixel", {8'(opix[0]), ox[0], oy[0]}, {8'd13, 32'd3, 32'd2});

        // Long random run, dummies biased towards the expected value.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic v;
            logic [7:0] p;
            v = ($urandom_range(0, 99) < 70);
            p = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            step(v, p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
